// File: rtl/cdc_pkg.sv
// Shared constants for clock-domain-crossing blocks: synchronizer depth
// defaults and the minimum depth considered safe.
package cdc_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int MIN_SYNC_STAGES     = 2;

    // True when a requested synchronizer depth is deep enough to be safe.
    function automatic bit sync_stages_legal(input int n);
        return n >= MIN_SYNC_STAGES;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic single-bit synchronizer: a shift chain of STAGES flops clocked in
// the destination domain, asynchronously forced to RST_VAL.
module sync_chain
    import cdc_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEFAULT,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the chain; the first flop may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_synchronizer.sv
// Toggle-based pulse synchronizer with acknowledge feedback. A source pulse
// flips src_tog_q; the destination detects the toggle edge and echoes its
// state back, and the source stays busy until the echo matches.
module pulse_synchronizer
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic i_clk,
    input  logic o_clk,
    input  logic rst_n,
    input  logic i_pulse,
    output logic i_busy,
    output logic i_drop,
    output logic o_pulse
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
        $error("pulse_synchronizer: SYNC_STAGES=%0d is below MIN_SYNC_STAGES=%0d",
               SYNC_STAGES, MIN_SYNC_STAGES);
    end

    // Per-domain "out of reset" flags: cleared instantly by rst_n, set only
    // after SYNC_STAGES clean edges of the local clock.
    logic src_rdy;
    logic dst_rdy;

    // Source domain state
    logic src_tog_q, src_tog_d;
    logic drop_q, drop_d;
    logic ack_sync;
    logic src_busy;

    // Destination domain state
    logic dst_sync;
    logic dst_q;
    logic o_pulse_q, o_pulse_d;

    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_src_rst_sync (
        .clk (i_clk),
        .rst (rst_n),
        .d   (1'b1),
        .q   (src_rdy)
    );

    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dst_rst_sync (
        .clk (o_clk),
        .rst (rst_n),
        .d   (1'b1),
        .q   (dst_rdy)
    );

    // Forward path: the source toggle is a flop output, nothing combinational
    // sits between it and the first destination flop.
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_fwd_sync (
        .clk (o_clk),
        .rst (rst_n),
        .d   (src_tog_q),
        .q   (dst_sync)
    );

    // Feedback path: the destination's copy of the toggle returns as the acknowledge.
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ack_sync (
        .clk (i_clk),
        .rst (rst_n),
        .d   (dst_q),
        .q   (ack_sync)
    );

    // Busy while the toggle sent has not yet come back through the acknowledge path.
    assign src_busy = src_tog_q ^ ack_sync;

    // Accept a pulse when idle by flipping the toggle; flag it as dropped when busy.
    always_comb begin
        src_tog_d = src_tog_q;
        drop_d    = 1'b0;
        if (i_pulse) begin
            if (src_busy) begin
                drop_d = 1'b1;
            end else begin
                src_tog_d = ~src_tog_q;
            end
        end
    end

    // Source-domain registers, held idle until the local reset release has synchronized.
    always_ff @(posedge i_clk or posedge rst_n) begin
        if (rst_n) begin
            src_tog_q <= 1'b0;
            drop_q    <= 1'b0;
        end else if (!src_rdy) begin
            src_tog_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            src_tog_q <= src_tog_d;
            drop_q    <= drop_d;
        end
    end

    // Any difference between the synchronized toggle and its delayed copy is one event.
    always_comb begin
        o_pulse_d = dst_sync ^ dst_q;
    end

    // Destination-domain registers: delayed toggle copy and the registered output pulse.
    always_ff @(posedge o_clk or posedge rst_n) begin
        if (rst_n) begin
            dst_q     <= 1'b0;
            o_pulse_q <= 1'b0;
        end else if (!dst_rdy) begin
            dst_q     <= 1'b0;
            o_pulse_q <= 1'b0;
        end else begin
            dst_q     <= dst_sync;
            o_pulse_q <= o_pulse_d;
        end
    end

    assign i_busy  = src_busy;
    assign i_drop  = drop_q;
    assign o_pulse = o_pulse_q;

endmodule

// File: tb/tb_pulse_synchronizer.sv
// Directed bench for pulse_synchronizer with a scoreboard of expected
// destination pulses: one entry per accepted source pulse, consumed when an
// o_pulse is observed.
`timescale 1ns/1ps
module tb_pulse_synchronizer;

    localparam int SYNC_STAGES = 2;

    logic i_clk   = 1'b0;
    logic o_clk   = 1'b0;
    logic rst_n   = 1'b0;
    logic i_pulse = 1'b0;
    logic i_busy, i_drop, o_pulse;

    int i_half = 5;
    int o_half = 10;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int next_id = 0;
    int seen = 0;
    bit prev_hi = 1'b0;

    always #(i_half) i_clk = ~i_clk;
    always #(o_half) o_clk = ~o_clk;

    pulse_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk   (i_clk),
        .o_clk   (o_clk),
        .rst_n   (rst_n),
        .i_pulse (i_pulse),
        .i_busy  (i_busy),
        .i_drop  (i_drop),
        .o_pulse (o_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every observed o_pulse must be one cycle wide and must match a queued event.
    always @(negedge o_clk) begin
        if (o_pulse === 1'b1) begin
            seen++;
            check("o_pulse_single_cycle", {31'd0, prev_hi}, 32'd0);
            check("o_pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            prev_hi = 1'b1;
        end else begin
            prev_hi = 1'b0;
        end
    end

    // One-cycle pulse that the source is expected to accept.
    task automatic send(input string tag, input bit deliver);
        @(posedge i_clk); #1;
        i_pulse = 1'b1;
        @(posedge i_clk); #1;
        i_pulse = 1'b0;
        if (deliver) exp_q.push_back(next_id++);
        check({tag, "_busy_set"}, {31'd0, i_busy}, 32'd1);
        check({tag, "_no_drop"}, {31'd0, i_drop}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (i_busy !== 1'b0 && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        check(tag, {31'd0, n < 200}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || i_busy !== 1'b0) && n < 400) begin
            @(posedge o_clk); #1;
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset asserted for 150ns
        rst_n = 1'b1;
        #100;
        check("rst_o_pulse", {31'd0, o_pulse}, 32'd0);
        check("rst_busy", {31'd0, i_busy}, 32'd0);
        check("rst_drop", {31'd0, i_drop}, 32'd0);
        #50;
        rst_n = 1'b0;
        repeat (6) @(posedge o_clk);
        #1;
        check("post_rst_busy", {31'd0, i_busy}, 32'd0);
        check("post_rst_no_pulse", seen, 32'd0);

        // Single pulse, fast source to slow destination
        base = seen;
        send("single", 1'b1);
        n = 0;
        while (o_pulse !== 1'b1 && n < 10) begin
            @(posedge o_clk); #1;
            n++;
        end
        check("single_fwd_latency", {31'd0, n >= SYNC_STAGES + 1 && n <= SYNC_STAGES + 2}, 32'd1);
        n = 0;
        while (i_busy !== 1'b0 && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("single_ack_latency", {31'd0, n >= SYNC_STAGES && n <= SYNC_STAGES + 2}, 32'd1);
        wait_drain("single_drain");
        repeat (4) @(posedge o_clk);
        check("single_count", seen - base, 32'd1);

        // i_pulse held for three source cycles: first accepted, two dropped
        base = seen;
        @(posedge i_clk); #1;
        i_pulse = 1'b1;
        @(posedge i_clk); #1;
        exp_q.push_back(next_id++);
        check("hold_busy_set", {31'd0, i_busy}, 32'd1);
        check("hold_first_not_dropped", {31'd0, i_drop}, 32'd0);
        @(posedge i_clk); #1;
        check("hold_drop_cycle1", {31'd0, i_drop}, 32'd1);
        @(posedge i_clk); #1;
        i_pulse = 1'b0;
        check("hold_drop_cycle2", {31'd0, i_drop}, 32'd1);
        @(posedge i_clk); #1;
        check("hold_drop_clear", {31'd0, i_drop}, 32'd0);
        wait_drain("hold_drain");
        repeat (4) @(posedge o_clk);
        check("hold_count", seen - base, 32'd1);

        // Swapped clocks: slow source, fast destination, two spaced pulses
        wait_idle("swap_idle");
        i_half = 10;
        o_half = 5;
        repeat (4) @(posedge i_clk);
        base = seen;
        send("swap1", 1'b1);
        wait_drain("swap1_drain");
        repeat (5) @(posedge i_clk);
        send("swap2", 1'b1);
        wait_drain("swap2_drain");
        repeat (6) @(posedge o_clk);
        check("swap_count", seen - base, 32'd2);

        // Eight pulses, each on the first source edge after busy falls
        base = seen;
        for (int k = 0; k < 8; k++) begin
            wait_idle("b2b_idle");
            i_pulse = 1'b1;
            @(posedge i_clk); #1;
            i_pulse = 1'b0;
            exp_q.push_back(next_id++);
            check("b2b_accept", {31'd0, i_busy}, 32'd1);
            check("b2b_no_drop", {31'd0, i_drop}, 32'd0);
        end
        wait_drain("b2b_drain");
        repeat (6) @(posedge o_clk);
        check("b2b_count", seen - base, 32'd8);

        // Reset one destination cycle after a pulse is accepted
        i_half = 5;
        o_half = 10;
        repeat (4) @(posedge o_clk);
        base = seen;
        send("midrst", 1'b0);
        @(posedge o_clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_busy_cleared", {31'd0, i_busy}, 32'd0);
        check("midrst_o_pulse_low", {31'd0, o_pulse}, 32'd0);
        #60;
        rst_n = 1'b0;
        repeat (10) @(posedge o_clk);
        #1;
        check("midrst_no_pulse", seen - base, 32'd0);
        check("midrst_idle", {31'd0, i_busy}, 32'd0);
        send("after_rst", 1'b1);
        wait_drain("after_rst_drain");
        repeat (4) @(posedge o_clk);
        check("after_rst_count", seen - base, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
